// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
// Handshake: Start is a request held by EX; it is taken on a rising edge only when Busy=0 and Flush=0, and Stall tells EX to keep holding it.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             HiLoRead;
  logic             Flush;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             Busy;
  logic             Done;
  logic             Stall;
  logic [1:0]       dbg_state;

  modport master (
    output Start, Op, A, B, HiLoRead, Flush,
    input  Hi, Lo, Busy, Done, Stall, dbg_state
  );

  modport slave (
    input  Start, Op, A, B, HiLoRead, Flush,
    output Hi, Lo, Busy, Done, Stall, dbg_state
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide with architectural HI/LO.
// Optional MADD/MADDU accumulate is enabled by defining MULDIV_MADD_EN.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic          CLK,
  input  logic          RST,
  muldiv_unit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      cnt;
  logic [WIDTH:0]     acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   opnd;
  logic               is_div, neg_res, neg_rem, div_zero;
  logic [WIDTH-1:0]   hi, lo;
  logic               done;
`ifdef MULDIV_MADD_EN
  logic               is_madd;
`endif

  logic               signed_op, sign_a, sign_b, is_arith, accept;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, mul_pick, div_sh, div_diff;
  logic [2*WIDTH-1:0] prod_mag, prod;
  logic [WIDTH-1:0]   quo_fix, rem_fix, hi_fix, lo_fix;

  always_comb begin
    signed_op = ~bus.Op[0];
    sign_a    = signed_op & bus.A[WIDTH-1];
    sign_b    = signed_op & bus.B[WIDTH-1];
    mag_a     = sign_a ? -bus.A : bus.A;
    mag_b     = sign_b ? -bus.B : bus.B;
`ifdef MULDIV_MADD_EN
    is_arith  = (bus.Op[2:1] != 2'b10);
`else
    is_arith  = ~bus.Op[2];
`endif
    accept    = (state == IDLE) && bus.Start && !bus.Flush && is_arith;
  end

  // One iteration of each algorithm; acc_hi carries the extra bit for the add/subtract.
  always_comb begin
    mul_sum  = acc_hi + {1'b0, opnd};
    mul_pick = acc_lo[0] ? mul_sum : acc_hi;
    div_sh   = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    div_diff = div_sh - {1'b0, opnd};
  end

  always_comb begin
    prod_mag = {acc_hi[WIDTH-1:0], acc_lo};
    prod     = neg_res ? -prod_mag : prod_mag;
`ifdef MULDIV_MADD_EN
    if (is_madd) prod = prod + {hi, lo};
`endif
    quo_fix  = div_zero ? '1 : (neg_res ? -acc_lo : acc_lo);
    rem_fix  = neg_rem ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
    hi_fix   = is_div ? rem_fix : prod[2*WIDTH-1:WIDTH];
    lo_fix   = is_div ? quo_fix : prod[WIDTH-1:0];
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = CALC;
      CALC:    if (cnt == CW'(1)) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (bus.Flush) state_nx = IDLE;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
`ifdef MULDIV_MADD_EN
      is_madd  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (bus.Flush) begin
        cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              cnt      <= CW'(WIDTH);
              acc_hi   <= '0;
              is_div   <= (bus.Op[2:1] == 2'b01);
              // Divide keeps the dividend in acc_lo; multiply keeps the multiplier there.
              acc_lo   <= (bus.Op[2:1] == 2'b01) ? mag_a : mag_b;
              opnd     <= (bus.Op[2:1] == 2'b01) ? mag_b : mag_a;
              neg_res  <= sign_a ^ sign_b;
              neg_rem  <= sign_a;
              div_zero <= (bus.B == '0);
`ifdef MULDIV_MADD_EN
              is_madd  <= (bus.Op[2:1] == 2'b11);
`endif
            end else if (bus.Start && bus.Op == 3'b100) begin
              hi <= bus.A;
            end else if (bus.Start && bus.Op == 3'b101) begin
              lo <= bus.A;
            end
          end
          CALC: begin
            cnt <= cnt - CW'(1);
            if (is_div) begin
              acc_hi <= div_diff[WIDTH] ? div_sh : div_diff;
              acc_lo <= {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
            end else begin
              acc_hi <= {1'b0, mul_pick[WIDTH:1]};
              acc_lo <= {mul_pick[0], acc_lo[WIDTH-1:1]};
            end
          end
          FIX: begin
            hi   <= hi_fix;
            lo   <= lo_fix;
            done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.Hi        = hi;
  assign bus.Lo        = lo;
  assign bus.Busy      = (state != IDLE);
  assign bus.Done      = done;
  assign bus.Stall     = (state != IDLE) & (bus.HiLoRead | bus.Start);
  assign bus.dbg_state = state;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide unit with architectural HI/LO registers. Sits beside the EX-stage ALU and drives the EX stall path through the hazard controller. Handles signed and unsigned MULT/DIV over a configurable operand width, and the MTHI/MTLO writes. Stalls the pipeline on HI/LO reads and on new requests while an operation is in flight.

Parameters:
WIDTH, 32, operand width in bits; HI/LO are each WIDTH bits; must be at least 4 and even.
CW, $clog2(WIDTH+1), width of the iteration counter; derived, not to be overridden.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RST  input  1  synchronous reset, active-high.
Start  input  1  request valid in EX this cycle.
Op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110 MADD, 111 MADDU.
A  input  WIDTH  rs operand: multiplicand/dividend, or the MTHI/MTLO data.
B  input  WIDTH  rt operand: multiplier/divisor.
HiLoRead  input  1  MFHI/MFLO in EX this cycle.
Flush  input  1  abort any in-flight operation (exception/ERET).
Hi  output  WIDTH  HI register.
Lo  output  WIDTH  LO register.
Busy  output  1  an operation is in flight.
Done  output  1  one-cycle pulse after HI/LO is written by MULT/DIV/MADD.
Stall  output  1  Busy & (HiLoRead | Start); fed to the hazard controller.

Behaviour:
- Reset: Hi=0, Lo=0, Busy=0, Done=0, state IDLE, counter=0. A reset mid-operation discards the operation, and HI/LO become 0.
- States: IDLE, CALC, FIX. Busy = (state != IDLE).
- Accept: on the edge where state is IDLE, Start=1 and Flush=0.
  - MULT/MULTU/DIV/DIVU/MADD/MADDU: latch operand magnitudes and result signs, set counter=WIDTH, go to CALC.
  - MTHI writes Hi=A at that same edge and stays IDLE. MTLO writes Lo=A the same way. Neither raises Busy or Done.
- While Busy, Start is not accepted; Stall holds the instruction in EX until Busy falls.
- CALC:
  - Radix-2 shift-add multiply or restoring divide, one bit per cycle.
  - Counter decrements each cycle. At counter=1, the next state is FIX.
- FIX, one cycle:
  - Apply sign correction and write Hi/Lo at the edge.
  - Go to IDLE. Done=1 for the following cycle.
- Latency: Busy is high for exactly WIDTH+1 cycles after the accepting edge. Hi/Lo hold their old values until the FIX edge.
- Multiply: the 2*WIDTH-bit product goes to {Hi,Lo}. Signed ops use two's complement.
- Divide:
  - Lo=quotient, truncated toward zero. Hi=remainder, carrying the sign of the dividend.
  - Divide by zero: Lo = all ones, Hi = A (unsigned and signed alike).
  - Signed MIN/-1: Lo=MIN, Hi=0. This is the natural magnitude-wrap result, with no trap.
- Flush: at the next edge, state goes to IDLE and the counter clears. Hi/Lo are unchanged and Done is not pulsed.
- Flush and Start in the same cycle: Flush wins and Start is ignored. This includes MTHI/MTLO.
- Stall is combinational. HiLoRead while IDLE never stalls; Hi/Lo are read directly.

Optional Feature:
MULDIV_MADD_EN
- Defined: MADD/MADDU compute {Hi,Lo} + product (signed/unsigned, modulo 2^(2*WIDTH)). The addition happens in FIX using the {Hi,Lo} value present at the FIX edge. Latency is the same as MULT.
- Undefined: Op 110/111 are ignored. Nothing is accepted, Busy is not raised, and Hi/Lo are unchanged.

Test Plan:
All scenarios use WIDTH=32.
- MULT A=0xFFFFFFFF, B=7:
  - Busy is high for 33 cycles, then Done pulses once.
  - Hi=0xFFFFFFFF, Lo=0xFFFFFFF9.
- MULTU A=B=0xFFFFFFFF:
  - Hi=0xFFFFFFFE, Lo=0x00000001.
  - HiLoRead asserted during Busy gives Stall=1 on every busy cycle and Stall=0 after.
- DIV -7/2:
  - Lo=0xFFFFFFFD, Hi=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF gives Lo=0x80000000, Hi=0.
  - DIVU 7/0 gives Lo=0xFFFFFFFF, Hi=7.
- MTHI 0x1234, then MTLO 0x5678, with no Busy: Hi=0x1234 and Lo=0x5678, each written at its accepting edge.
  - Then DIVU 100/7 with Flush asserted on busy cycle 10: Busy falls at the next edge, Done never pulses, and Hi/Lo stay 0x1234/0x5678.
  - Start asserted with Flush in the same idle cycle is ignored.
- Mid-operation and MADD cases:
  - RST asserted during MULT cycle 5: Hi=Lo=0 and Busy=0 at the next edge. A subsequent MULT 3×4 gives Lo=12, Hi=0.
  - With MULDIV_MADD_EN: {Hi,Lo}=5, then MADD 3×4 gives Lo=0x11, Hi=0.
  - Without the macro: the same MADD leaves Lo=5 and Busy stays 0.
